// File: rtl/mips_mem_ctrl.sv
// Memory controller between the multicycle mips core and a single-port RAM.
// Posted write buffer with read forwarding and programmable RAM wait states.
//
// Ports:
//   clk, reset           clock, async active-low reset
//   memread, memwrite    core requests, held until memready
//   adr, writedata       core address / write data
//   memdata, memready    read data and one-cycle completion pulse
//   ram_en, ram_we       RAM access / write enable
//   ram_adr, ram_wdata   RAM address / write data (hold when idle)
//   ram_rdata            RAM read data, valid in last access cycle
//   wbuf_count/full      write-buffer occupancy
module mips_mem_ctrl #(
  parameter int WIDTH       = 8,
  parameter int WBUF_DEPTH  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            memread,
  input  logic                            memwrite,
  input  logic [WIDTH-1:0]                adr,
  input  logic [WIDTH-1:0]                writedata,
  output logic [WIDTH-1:0]                memdata,
  output logic                            memready,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [WIDTH-1:0]                ram_adr,
  output logic [WIDTH-1:0]                ram_wdata,
  input  logic [WIDTH-1:0]                ram_rdata,
  output logic [$clog2(WBUF_DEPTH+1)-1:0] wbuf_count,
  output logic                            wbuf_full
);

  localparam int PW  = $clog2(WBUF_DEPTH);
  localparam int CNW = $clog2(WBUF_DEPTH+1);
  localparam int CW  = (WAIT_CYCLES > 0) ?
                       $clog2(WAIT_CYCLES+1) : 1;

  typedef enum logic [1:0] {
    IDLE, RD_ACC, WR_ACC, RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [WIDTH-1:0] wb_adr  [WBUF_DEPTH];
  logic [WIDTH-1:0] wb_data [WBUF_DEPTH];

  logic             hit;
  logic [WIDTH-1:0] hit_data;
  logic [PW-1:0]    idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = head + PW'(i);
      if (CNW'(i) < wbuf_count && wb_adr[idx] == adr) begin
        hit      = 1'b1;
        hit_data = wb_data[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      head       <= '0;
      tail       <= '0;
      memdata    <= '0;
      memready   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_adr    <= '0;
      ram_wdata  <= '0;
      wbuf_count <= '0;
      wbuf_full  <= 1'b0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_adr[i]  <= '0;
        wb_data[i] <= '0;
      end
    end else begin
      memready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (memread) begin
            if (hit) begin
              memdata  <= hit_data;
              memready <= 1'b1;
              state    <= RESP;
            end else begin
              ram_en  <= 1'b1;
              ram_we  <= 1'b0;
              ram_adr <= adr;
              cnt     <= CW'(WAIT_CYCLES);
              state   <= RD_ACC;
            end
          end else if (memwrite && !wbuf_full) begin
            wb_adr[tail]  <= adr;
            wb_data[tail] <= writedata;
            tail          <= tail + 1'b1;
            wbuf_count    <= wbuf_count + CNW'(1);
            wbuf_full     <= (wbuf_count ==
                              CNW'(WBUF_DEPTH-1));
            memready      <= 1'b1;
            state         <= RESP;
          end else if (wbuf_count != '0) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_adr   <= wb_adr[head];
            ram_wdata <= wb_data[head];
            cnt       <= CW'(WAIT_CYCLES);
            state     <= WR_ACC;
          end
        end
        RD_ACC: begin
          if (cnt == '0) begin
            memdata  <= ram_rdata;
            memready <= 1'b1;
            ram_en   <= 1'b0;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_ACC: begin
          if (cnt == '0) begin
            head       <= head + 1'b1;
            wbuf_count <= wbuf_count - CNW'(1);
            wbuf_full  <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Testbench for mips_mem_ctrl: WAIT_CYCLES=2, WBUF_DEPTH=4, WIDTH=8.
// Directed vector table plus drain and reset sequences.
module tb_mips_mem_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = '0;
  logic [7:0] writedata = '0;
  logic [7:0] memdata;
  logic       memready;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_adr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [2:0] wbuf_count;
  logic       wbuf_full;

  mips_mem_ctrl #(
    .WIDTH(8), .WBUF_DEPTH(4), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata),
    .memdata(memdata), .memready(memready),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_adr(ram_adr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .wbuf_count(wbuf_count), .wbuf_full(wbuf_full)
  );

  always #5 clk = ~clk;

  // RAM model with a preload port and a write log.
  logic [7:0]  mem [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_a = '0;
  logic [7:0]  ld_d = '0;
  logic        prev_wr = 1'b0;
  logic [15:0] wlog [$];
  int          we_no_en = 0;

  assign ram_rdata = mem[ram_adr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    if (ram_en && ram_we) mem[ram_adr] <= ram_wdata;
    if (ram_en && ram_we && !prev_wr)
      wlog.push_back({ram_adr, ram_wdata});
    if (ram_we && !ram_en) we_no_en++;
    prev_wr <= ram_en && ram_we;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a,
                      input logic [7:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic do_req(input logic r, input logic w,
                        input logic [7:0] a,
                        input logic [7:0] d,
                        output int lat, output int en_c,
                        output int we_c,
                        output logic [7:0] data,
                        output logic [2:0] cnt,
                        output logic full);
    memread = r; memwrite = w;
    adr = a; writedata = d;
    lat = 0; en_c = 0; we_c = 0;
    data = '0; cnt = '0; full = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      en_c += int'(ram_en);
      we_c += int'(ram_we);
      if (memready) begin
        data = memdata;
        cnt  = wbuf_count;
        full = wbuf_full;
        break;
      end
    end
    memread = 1'b0; memwrite = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    int         lat;
    logic [7:0] data;
    int         en;
    int         we;
    int         cnt;
    logic       full;
  } vec_t;

  vec_t tv[15];

  task automatic run_vec(input int k);
    int lat, en_c, we_c;
    logic [7:0] data;
    logic [2:0] cnt;
    logic full;
    string s;
    do_req(tv[k].rd, tv[k].wr, tv[k].a, tv[k].d,
           lat, en_c, we_c, data, cnt, full);
    s = $sformatf("v%0d", k);
    check({s, " latency"}, lat, tv[k].lat);
    check({s, " memdata"}, int'(data), int'(tv[k].data));
    check({s, " ram_en cycles"}, en_c, tv[k].en);
    check({s, " ram_we cycles"}, we_c, tv[k].we);
    check({s, " wbuf_count"}, int'(cnt), tv[k].cnt);
    check({s, " wbuf_full"}, int'(full), int'(tv[k].full));
  endtask

  initial begin
    int we_c, en_c, n;
    tv[0]  = '{1,0,8'h10,8'h00,4,8'h5A,3,0,0,0};
    tv[1]  = '{0,1,8'h20,8'h33,1,8'h5A,0,0,1,0};
    tv[2]  = '{1,0,8'h20,8'h00,1,8'h33,0,0,1,0};
    tv[3]  = '{1,1,8'h30,8'h77,4,8'h99,3,0,1,0};
    tv[4]  = '{1,0,8'h40,8'h00,4,8'hC3,3,0,1,0};
    tv[5]  = '{0,1,8'h20,8'h11,1,8'hC3,0,0,2,0};
    tv[6]  = '{0,1,8'h20,8'h22,1,8'hC3,0,0,3,0};
    tv[7]  = '{1,0,8'h20,8'h00,1,8'h22,0,0,3,0};
    tv[8]  = '{0,1,8'h50,8'hA0,1,8'h22,0,0,1,0};
    tv[9]  = '{0,1,8'h51,8'hA1,1,8'h22,0,0,2,0};
    tv[10] = '{0,1,8'h52,8'hA2,1,8'h22,0,0,3,0};
    tv[11] = '{0,1,8'h53,8'hA3,1,8'h22,0,0,4,1};
    tv[12] = '{0,1,8'h54,8'hA4,5,8'h22,3,3,4,1};
    tv[13] = '{1,0,8'h50,8'h00,4,8'hA0,3,0,4,1};
    tv[14] = '{1,0,8'h54,8'h00,1,8'hA4,0,0,4,1};

    // Reset held while the RAM is preloaded.
    load(8'h10, 8'h5A);
    load(8'h30, 8'h99);
    load(8'h40, 8'hC3);
    check("reset memready", int'(memready), 0);
    check("reset ram_en", int'(ram_en), 0);
    check("reset memdata", int'(memdata), 0);
    check("reset wbuf_count", int'(wbuf_count), 0);
    reset = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(k);

    // Idle: three buffered writes to 0x20 drain in order.
    wlog.delete();
    we_c = 0;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      we_c += int'(ram_we);
      if (wbuf_count == 3'd0 && !ram_en) break;
    end
    check("drain done", int'(wbuf_count), 0);
    check("drain we cycles", we_c, 9);
    check("drain log size", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("drain w0", int'(wlog[0]), 16'h2033);
      check("drain w1", int'(wlog[1]), 16'h2011);
      check("drain w2", int'(wlog[2]), 16'h2022);
    end
    check("ram 0x20", int'(mem[8'h20]), 8'h22);
    check("ram_adr hold", int'(ram_adr), 8'h20);
    check("ram_wdata hold", int'(ram_wdata), 8'h22);

    for (int k = 8; k < 15; k++) run_vec(k);

    // Reset in the middle of a read access.
    memread = 1'b1; adr = 8'h60;
    @(posedge clk); #1;
    check("rd_acc ram_en", int'(ram_en), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid rst ram_en", int'(ram_en), 0);
    check("mid rst ram_adr", int'(ram_adr), 0);
    check("mid rst ram_wdata", int'(ram_wdata), 0);
    check("mid rst memdata", int'(memdata), 0);
    check("mid rst wbuf_count", int'(wbuf_count), 0);
    check("mid rst wbuf_full", int'(wbuf_full), 0);
    memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    en_c = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      en_c += int'(ram_en) + int'(memready);
    end
    check("post rst quiet", en_c, 0);
    check("we without en", we_no_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
